// File: rtl/pmul_result_serializer_if.sv
// Bundle for the P_MUL product input and the narrow output word stream,
// plus the FIFO status outputs of the serializer.
interface pmul_result_serializer_if #(
   parameter int DATA_W = 96,
   parameter int WORD_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic              out_last;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              overflow;
   logic [7:0]        drop_cnt;

   // Environment side: feeds products, consumes words, observes status
   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_last, fifo_cnt, overflow, drop_cnt
   );

   // Serializer side
   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_last, fifo_cnt, overflow, drop_cnt
   );
endinterface

// File: rtl/pmul_result_serializer.sv
// Buffers 96-bit P_MUL products in a small FIFO (P_MUL cannot be stalled)
// and streams each one out least-significant word first on a valid/ready
// bus. Products arriving while the FIFO is full are dropped and counted.
module pmul_result_serializer #(
   parameter int DATA_W = 96,
   parameter int WORD_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic clk,
   input  logic rst_n,
   pmul_result_serializer_if.slave bus
);
   localparam int BEATS  = DATA_W / WORD_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic [BEAT_W-1:0] beat_idx;
   logic              valid_q;
   logic              ovf_q;
   logic [7:0]        drop_q;
   logic              full;
   logic              xfer;
   logic              pop;
   logic              push;
   logic              drop;
   logic [DATA_W-1:0] head;

   // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
   // still accepts a product when its head is leaving
   always_comb begin
      full     = (cnt == FULL_CNT);
      xfer     = valid_q && bus.out_ready;
      pop      = xfer && (beat_idx == LAST_BEAT);
      push     = bus.in_valid && (!full || pop);
      drop     = bus.in_valid && !push;
      cnt_next = cnt + CNT_W'(push) - CNT_W'(pop);
   end

   // Product storage; contents need no reset because the count gates them
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   // Pointers, occupancy, word position and loss tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         valid_q  <= 1'b0;
         beat_idx <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         cnt     <= cnt_next;
         valid_q <= (cnt_next != '0);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            beat_idx <= '0;
         end else if (xfer) begin
            beat_idx <= beat_idx + BEAT_W'(1);
         end
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end
      end
   end

   // Word select from the head entry; forced to zero while nothing is held so
   // reset clears the visible word immediately
   always_comb begin
      head          = mem[rd_ptr];
      bus.out_valid = valid_q;
      bus.out_data  = valid_q ? head[WORD_W*beat_idx +: WORD_W] : '0;
      bus.out_last  = valid_q && (beat_idx == LAST_BEAT);
      bus.fifo_cnt  = cnt;
      bus.overflow  = ovf_q;
      bus.drop_cnt  = drop_q;
   end
endmodule

// File: tb/tb_pmul_result_serializer.sv
// Self-checking bench for pmul_result_serializer: directed scenarios plus a
// randomized run, all compared against a queue-based model of the FIFO.
module tb_pmul_result_serializer;
   localparam int DATA_W = 96;
   localparam int WORD_W = 32;
   localparam int DEPTH  = 4;
   localparam int BEATS  = DATA_W / WORD_W;
   localparam logic [DATA_W-1:0] PROD_ABC = 96'h0000000C_0000000B_0000000A;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   logic [DATA_W-1:0] mq [$];
   int                mpos;
   int                mdrop;
   bit                movf;

   pmul_result_serializer_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

   pmul_result_serializer #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rand_prod();
      return {$urandom, $urandom, $urandom};
   endfunction

   function automatic logic [WORD_W-1:0] exp_word();
      logic [DATA_W-1:0] h;
      if (mq.size() == 0) return '0;
      h = mq[0];
      return h[mpos*WORD_W +: WORD_W];
   endfunction

   function automatic logic exp_last();
      return (mq.size() != 0) && (mpos == BEATS - 1);
   endfunction

   // Apply one cycle of inputs and advance the model to match the coming edge
   task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d, input logic r);
      int                sz;
      bit                popped;
      logic [DATA_W-1:0] gone;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      sz = mq.size();
      popped = 1'b0;
      if (r && sz != 0) begin
         if (mpos == BEATS - 1) begin
            gone = mq.pop_front();
            mpos = 0;
            popped = 1'b1;
         end else begin
            mpos++;
         end
      end
      if (v) begin
         if (sz < DEPTH || popped) mq.push_back(d);
         else begin
            movf = 1'b1;
            if (mdrop < 255) mdrop++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      mq.delete();
      mpos = 0;
      mdrop = 0;
      movf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      #3;
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
      tests_run++; if (bus.out_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_out_data got %h want 0", bus.out_data); end
      tests_run++; if (bus.out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_last got %b want 0", bus.out_last); end
      tests_run++; if (bus.fifo_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_fifo_cnt got %0d want 0", bus.fifo_cnt); end
      tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow got %b want 0", bus.overflow); end
      tests_run++; if (bus.drop_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_drop_cnt got %0d want 0", bus.drop_cnt); end
   endtask

   task automatic test_single();
      logic [WORD_W-1:0] words [3] = '{32'h0A, 32'h0B, 32'h0C};
      do_reset();
      drive_cycle(1'b1, PROD_ABC, 1'b1);
      tests_run++; if (bus.fifo_cnt !== 3'd1) begin tests_failed++; $display("[TB] FAIL single_cnt got %0d want 1", bus.fifo_cnt); end
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid[%0d] got %b want 1", i, bus.out_valid); end
         tests_run++; if (bus.out_data !== words[i]) begin tests_failed++; $display("[TB] FAIL single_data[%0d] got %h want %h", i, bus.out_data, words[i]); end
         tests_run++; if (bus.out_last !== (i == 2)) begin tests_failed++; $display("[TB] FAIL single_last[%0d] got %b want %b", i, bus.out_last, i == 2); end
         drive_cycle(1'b0, '0, 1'b1);
      end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_end_valid got %b want 0", bus.out_valid); end
      tests_run++; if (bus.fifo_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL single_end_cnt got %0d want 0", bus.fifo_cnt); end
   endtask

   task automatic test_backpressure();
      logic [WORD_W-1:0] words [3] = '{32'h0A, 32'h0B, 32'h0C};
      do_reset();
      drive_cycle(1'b1, PROD_ABC, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0A) begin tests_failed++; $display("[TB] FAIL stall_hold[%0d] got v=%b d=%h want v=1 d=0000000a", i, bus.out_valid, bus.out_data); end
         drive_cycle(1'b0, '0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (bus.out_data !== words[i] || bus.out_last !== (i == 2)) begin tests_failed++; $display("[TB] FAIL stall_drain[%0d] got d=%h l=%b want d=%h l=%b", i, bus.out_data, bus.out_last, words[i], i == 2); end
         drive_cycle(1'b0, '0, 1'b1);
      end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_end_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_burst();
      do_reset();
      repeat (6) drive_cycle(1'b1, rand_prod(), 1'b0);
      tests_run++; if (bus.fifo_cnt !== 3'd4) begin tests_failed++; $display("[TB] FAIL burst_cnt got %0d want 4", bus.fifo_cnt); end
      tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL burst_overflow got %b want 1", bus.overflow); end
      tests_run++; if (bus.drop_cnt !== 8'd2) begin tests_failed++; $display("[TB] FAIL burst_drop_cnt got %0d want 2", bus.drop_cnt); end
      for (int i = 0; i < 12; i++) begin
         tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_word() || bus.out_last !== exp_last()) begin tests_failed++; $display("[TB] FAIL burst_word[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b", i, bus.out_valid, bus.out_data, bus.out_last, exp_word(), exp_last()); end
         drive_cycle(1'b0, '0, 1'b1);
      end
      tests_run++; if (bus.out_valid !== 1'b0 || bus.fifo_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL burst_end got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.fifo_cnt); end
   endtask

   task automatic test_full_pop();
      do_reset();
      repeat (4) drive_cycle(1'b1, rand_prod(), 1'b0);
      drive_cycle(1'b0, '0, 1'b1);
      drive_cycle(1'b0, '0, 1'b1);
      tests_run++; if (bus.out_last !== 1'b1 || bus.fifo_cnt !== 3'd4) begin tests_failed++; $display("[TB] FAIL fullpop_pre got l=%b cnt=%0d want l=1 cnt=4", bus.out_last, bus.fifo_cnt); end
      drive_cycle(1'b1, rand_prod(), 1'b1);
      tests_run++; if (bus.fifo_cnt !== 3'd4) begin tests_failed++; $display("[TB] FAIL fullpop_cnt got %0d want 4", bus.fifo_cnt); end
      tests_run++; if (bus.drop_cnt !== 8'd0 || bus.overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL fullpop_nodrop got drop=%0d ovf=%b want drop=0 ovf=0", bus.drop_cnt, bus.overflow); end
      for (int i = 0; i < 12; i++) begin
         tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_word() || bus.out_last !== exp_last()) begin tests_failed++; $display("[TB] FAIL fullpop_word[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b", i, bus.out_valid, bus.out_data, bus.out_last, exp_word(), exp_last()); end
         drive_cycle(1'b0, '0, 1'b1);
      end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fullpop_end_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (3) drive_cycle(1'b1, rand_prod(), 1'b0);
      drive_cycle(1'b0, '0, 1'b1);
      drive_cycle(1'b0, '0, 1'b1);
      tests_run++; if (bus.out_data !== exp_word() || bus.fifo_cnt !== 3'd3) begin tests_failed++; $display("[TB] FAIL midrst_pre got d=%h cnt=%0d want d=%h cnt=3", bus.out_data, bus.fifo_cnt, exp_word()); end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_out got v=%b d=%h l=%b want all 0", bus.out_valid, bus.out_data, bus.out_last); end
      tests_run++; if (bus.fifo_cnt !== '0 || bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL midrst_status got cnt=%0d ovf=%b drop=%0d want all 0", bus.fifo_cnt, bus.overflow, bus.drop_cnt); end
      mq.delete();
      mpos = 0;
      mdrop = 0;
      movf = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_cycle(1'b1, PROD_ABC, 1'b0);
      tests_run++; if (bus.out_data !== 32'h0A || bus.fifo_cnt !== 3'd1 || bus.out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_restart got d=%h cnt=%0d l=%b want d=0000000a cnt=1 l=0", bus.out_data, bus.fifo_cnt, bus.out_last); end
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (bus.out_data !== exp_word() || bus.out_last !== exp_last()) begin tests_failed++; $display("[TB] FAIL midrst_word[%0d] got d=%h l=%b want d=%h l=%b", i, bus.out_data, bus.out_last, exp_word(), exp_last()); end
         drive_cycle(1'b0, '0, 1'b1);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         tests_run++; if (bus.out_valid !== (mq.size() != 0)) begin tests_failed++; $display("[TB] FAIL rand_valid[%0d] got %b want %b", i, bus.out_valid, mq.size() != 0); end
         tests_run++; if (bus.fifo_cnt !== 3'(mq.size())) begin tests_failed++; $display("[TB] FAIL rand_cnt[%0d] got %0d want %0d", i, bus.fifo_cnt, mq.size()); end
         tests_run++; if (bus.out_last !== exp_last()) begin tests_failed++; $display("[TB] FAIL rand_last[%0d] got %b want %b", i, bus.out_last, exp_last()); end
         if (mq.size() != 0) begin
            tests_run++; if (bus.out_data !== exp_word()) begin tests_failed++; $display("[TB] FAIL rand_data[%0d] got %h want %h", i, bus.out_data, exp_word()); end
         end
         tests_run++; if (bus.overflow !== movf || bus.drop_cnt !== 8'(mdrop)) begin tests_failed++; $display("[TB] FAIL rand_drop[%0d] got ovf=%b drop=%0d want ovf=%b drop=%0d", i, bus.overflow, bus.drop_cnt, movf, mdrop); end
         drive_cycle(logic'($urandom_range(0, 9) < 5), rand_prod(), logic'($urandom_range(0, 9) < 6));
      end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (304) drive_cycle(1'b1, rand_prod(), 1'b0);
      tests_run++; if (bus.drop_cnt !== 8'd255) begin tests_failed++; $display("[TB] FAIL sat_drop_cnt got %0d want 255", bus.drop_cnt); end
      tests_run++; if (bus.overflow !== 1'b1 || bus.fifo_cnt !== 3'd4) begin tests_failed++; $display("[TB] FAIL sat_status got ovf=%b cnt=%0d want ovf=1 cnt=4", bus.overflow, bus.fifo_cnt); end
      repeat (5) drive_cycle(1'b1, rand_prod(), 1'b0);
      tests_run++; if (bus.drop_cnt !== 8'd255) begin tests_failed++; $display("[TB] FAIL sat_hold got %0d want 255", bus.drop_cnt); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_burst();
      test_full_pop();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
